// File: rtl/mem_stage.sv
// MEM pipeline stage between exe_stage and wb_stage.
// The stage latches the EXE->MEM bus. It aligns and sign-extends the
// synchronous data-SRAM read data, and keeps that read data while WB
// back-pressure stalls the stage. It forwards the result and exception
// status to EXE, to the hazard unit and to WB.
//
// Read-data hold FSM
//   state      | meaning
//   HOLD_EMPTY | SRAM read data is live this cycle; rd = data_sram_rdata
//   HOLD_FULL  | stalled after the live cycle; rd = captured rdata_r
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 125,
    parameter int MS_TO_WS_BUS_WD = 117
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [9:0]                 es_to_ms_addr,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ex_from_ws,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [9:0]                 ms_to_ws_addr,
    output logic [31:0]                ms_forward,
    output logic                       ex_from_ms,
    output logic                       ms_valid_h,
    output logic                       ms_res_from_cp0_h
);

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    logic                       ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] bus_r;
    logic [9:0]                 addr_r;
    logic [31:0]                rdata_r;
    hold_state_t                hold_state;
    logic                       flush;

    logic        f_eret, f_bd, f_mtc0_we, f_ex, f_res_cp0;
    logic [4:0]  f_cp0_addr, f_excode, f_dest;
    logic        f_lwl, f_lwr, f_ld_w, f_ld_h, f_ld_b, f_sign, f_gr_we;
    logic [31:0] f_rt, f_alu_res, f_pc;
    logic [1:0]  f_off;

    logic [31:0] rd;
    logic [15:0] half;
    logic [7:0]  byte_sel;
    logic [31:0] result;

    assign flush      = reset | ex_from_ws;
    assign ms_allowin = ~ms_valid | ws_allowin;

    // Stage occupancy. A flush wins over an accept on the same edge.
    always_ff @(posedge clk) begin
        if (flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // Payload registers are loaded only when an instruction is accepted.
    // They have no reset, because every consumer is qualified by ms_valid.
    always_ff @(posedge clk) begin
        if (!flush && es_to_ms_valid && ms_allowin) begin
            bus_r  <= es_to_ms_bus;
            addr_r <= es_to_ms_addr;
        end
    end

    // Capture the one-cycle SRAM data when WB stalls us, and keep it until
    // the stage advances.
    always_ff @(posedge clk) begin
        if (flush) begin
            hold_state <= HOLD_EMPTY;
        end else if (ms_allowin) begin
            hold_state <= HOLD_EMPTY;
        end else if (ms_valid && !ws_allowin && hold_state == HOLD_EMPTY) begin
            rdata_r    <= data_sram_rdata;
            hold_state <= HOLD_FULL;
        end
    end

    assign f_eret     = bus_r[124];
    assign f_bd       = bus_r[123];
    assign f_mtc0_we  = bus_r[122];
    assign f_cp0_addr = bus_r[121:117];
    assign f_ex       = bus_r[116];
    assign f_excode   = bus_r[115:111];
    assign f_res_cp0  = bus_r[110];
    assign f_lwl      = bus_r[109];
    assign f_lwr      = bus_r[108];
    assign f_rt       = bus_r[107:76];
    assign f_ld_w     = bus_r[75];
    assign f_ld_h     = bus_r[74];
    assign f_ld_b     = bus_r[73];
    assign f_sign     = bus_r[72];
    assign f_off      = bus_r[71:70];
    assign f_gr_we    = bus_r[69];
    assign f_dest     = bus_r[68:64];
    assign f_alu_res  = bus_r[63:32];
    assign f_pc       = bus_r[31:0];

    assign rd = (hold_state == HOLD_FULL) ? rdata_r : data_sram_rdata;

    // Select the addressed half-word and byte of the read data.
    always_comb begin
        half     = f_off[1] ? rd[31:16] : rd[15:0];
        byte_sel = rd[7:0];
        case (f_off)
            2'd0: byte_sel = rd[7:0];
            2'd1: byte_sel = rd[15:8];
            2'd2: byte_sel = rd[23:16];
            2'd3: byte_sel = rd[31:24];
            default: byte_sel = rd[7:0];
        endcase
    end

    // Build the writeback value. mfc0 and ALU ops pass alu_res through.
    always_comb begin
        result = f_alu_res;
        if (f_res_cp0) begin
            result = f_alu_res;
        end else if (f_ld_w) begin
            result = rd;
        end else if (f_ld_h) begin
            result = {{16{f_sign & half[15]}}, half};
        end else if (f_ld_b) begin
            result = {{24{f_sign & byte_sel[7]}}, byte_sel};
        end else if (f_lwl) begin
            case (f_off)
                2'd0: result = {rd[7:0],  f_rt[23:0]};
                2'd1: result = {rd[15:0], f_rt[15:0]};
                2'd2: result = {rd[23:0], f_rt[7:0]};
                default: result = rd;
            endcase
        end else if (f_lwr) begin
            case (f_off)
                2'd0: result = rd;
                2'd1: result = {f_rt[31:24], rd[31:8]};
                2'd2: result = {f_rt[31:16], rd[31:16]};
                default: result = {f_rt[31:8], rd[31:24]};
            endcase
        end
    end

    assign ms_to_ws_valid    = ms_valid;
    assign ms_valid_h        = ms_valid;
    assign ex_from_ms        = ms_valid & (f_ex | f_eret);
    assign ms_res_from_cp0_h = ms_valid & f_res_cp0;
    assign ms_forward        = ms_valid ? result : 32'd0;
    assign ms_to_ws_addr     = ms_valid ? addr_r : 10'd0;
    assign ms_to_ws_bus      = ms_valid ? {f_eret, f_bd, f_mtc0_we, f_cp0_addr, f_ex, f_excode,
                                           f_res_cp0, f_gr_we & ~f_ex, f_dest, result,
                                           f_alu_res, f_pc}
                                        : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [124:0] es_to_ms_bus;
    logic [9:0]   es_to_ms_addr;
    logic [31:0]  data_sram_rdata;
    logic         ex_from_ws;
    logic         ms_to_ws_valid;
    logic [116:0] ms_to_ws_bus;
    logic [9:0]   ms_to_ws_addr;
    logic [31:0]  ms_forward;
    logic         ex_from_ms;
    logic         ms_valid_h;
    logic         ms_res_from_cp0_h;

    int n_total = 0;
    int n_bad   = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .es_to_ms_addr     (es_to_ms_addr),
        .data_sram_rdata   (data_sram_rdata),
        .ex_from_ws        (ex_from_ws),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ws_addr     (ms_to_ws_addr),
        .ms_forward        (ms_forward),
        .ex_from_ms        (ex_from_ms),
        .ms_valid_h        (ms_valid_h),
        .ms_res_from_cp0_h (ms_res_from_cp0_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    function automatic logic [124:0] mk(
        input logic        ex,      input logic [4:0] excode, input logic res_cp0,
        input logic        lwl,     input logic lwr,          input logic [31:0] rt,
        input logic        ld_w,    input logic ld_h,         input logic ld_b,
        input logic        sign,    input logic gr_we,        input logic [4:0] dest,
        input logic [31:0] alu_res, input logic [31:0] pc);
        return {1'b0, 1'b0, 1'b0, 5'd0, ex, excode, res_cp0, lwl, lwr, rt,
                ld_w, ld_h, ld_b, sign, alu_res[1:0], gr_we, dest, alu_res, pc};
    endfunction

    // Sends one instruction through MEM without back-pressure and checks the result it produces.
    task automatic run_load(input string tag, input logic [124:0] b,
                            input logic [31:0] rdata, input logic [31:0] exp);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = rdata;
        at_neg();
        chk({tag, "_fwd"}, ms_forward, exp);
        chk({tag, "_res"}, ms_to_ws_bus[95:64], exp);
        step();
    endtask

    initial begin
        reset           = 1'b1;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        es_to_ms_addr   = 10'h000;
        data_sram_rdata = 32'h0;
        ex_from_ws      = 1'b0;
        step();
        step();
        at_neg();
        chk("rst_valid",   32'(ms_valid_h), 32'd0);
        chk("rst_wsvalid", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_allowin", 32'(ms_allowin), 32'd1);
        chk("rst_exms",    32'(ex_from_ms), 32'd0);
        chk("rst_fwd",     ms_forward, 32'd0);
        step();
        reset = 1'b0;

        // lb with sign extension at offset 3; the instruction spends exactly one cycle in MEM
        es_to_ms_valid = 1'b1;
        es_to_ms_addr  = 10'h2A5;
        es_to_ms_bus   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5'd7, 32'h0000_1003, 32'hBFC0_0010);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h8012_3456;
        at_neg();
        chk("t1_fwd",   ms_forward, 32'hFFFF_FF80);
        chk("t1_res",   ms_to_ws_bus[95:64], 32'hFFFF_FF80);
        chk("t1_grwe",  32'(ms_to_ws_bus[101]), 32'd1);
        chk("t1_dest",  32'(ms_to_ws_bus[100:96]), 32'd7);
        chk("t1_pc",    ms_to_ws_bus[31:0], 32'hBFC0_0010);
        chk("t1_addr",  32'(ms_to_ws_addr), 32'h2A5);
        chk("t1_valid", 32'(ms_to_ws_valid), 32'd1);
        step();
        at_neg();
        chk("t1_gone",  32'(ms_valid_h), 32'd0);
        step();

        // lw held across three stalled cycles; an instruction accepted on the release edge sees live data
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5'd3, 32'h0000_0100, 32'h0000_0040);
        step();
        es_to_ms_valid  = 1'b0;
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'hDEAD_BEEF;
        at_neg();
        chk("t2_c1_fwd",   ms_forward, 32'hDEAD_BEEF);
        chk("t2_c1_allow", 32'(ms_allowin), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            data_sram_rdata = 32'h0;
            at_neg();
            chk("t2_hold_fwd",   ms_forward, 32'hDEAD_BEEF);
            chk("t2_hold_allow", 32'(ms_allowin), 32'd0);
        end
        step();
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5'd4, 32'h0000_0104, 32'h0000_0044);
        at_neg();
        chk("t2_wb_res",   ms_to_ws_bus[95:64], 32'hDEAD_BEEF);
        chk("t2_wb_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("t2_wb_allow", 32'(ms_allowin), 32'd1);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h0BAD_F00D;
        at_neg();
        chk("t2_b2b_fwd",  ms_forward, 32'h0BAD_F00D);
        step();

        // alignment cases
        run_load("lwl1", mk(0,0,0,1,0,32'h1122_3344,0,0,0,0,1,5'd1,32'h0000_2001,0), 32'hAABB_CCDD, 32'hCCDD_3344);
        run_load("lwr2", mk(0,0,0,0,1,32'h1122_3344,0,0,0,0,1,5'd1,32'h0000_2002,0), 32'hAABB_CCDD, 32'h1122_AABB);
        run_load("lwl0", mk(0,0,0,1,0,32'h1122_3344,0,0,0,0,1,5'd1,32'h0000_2000,0), 32'hAABB_CCDD, 32'hDD22_3344);
        run_load("lwl3", mk(0,0,0,1,0,32'h1122_3344,0,0,0,0,1,5'd1,32'h0000_2003,0), 32'hAABB_CCDD, 32'hAABB_CCDD);
        run_load("lwr0", mk(0,0,0,0,1,32'h1122_3344,0,0,0,0,1,5'd1,32'h0000_2000,0), 32'hAABB_CCDD, 32'hAABB_CCDD);
        run_load("lwr3", mk(0,0,0,0,1,32'h1122_3344,0,0,0,0,1,5'd1,32'h0000_2003,0), 32'hAABB_CCDD, 32'h1122_33AA);
        run_load("lh2s", mk(0,0,0,0,0,0,0,1,0,1,1,5'd2,32'h0000_3002,0), 32'h8000_1234, 32'hFFFF_8000);
        run_load("lhu0", mk(0,0,0,0,0,0,0,1,0,0,1,5'd2,32'h0000_3000,0), 32'h1234_F00D, 32'h0000_F00D);
        run_load("lbu1", mk(0,0,0,0,0,0,0,0,1,0,1,5'd2,32'h0000_3001,0), 32'h0000_AB00, 32'h0000_00AB);
        run_load("lb0s", mk(0,0,0,0,0,0,0,0,1,1,1,5'd2,32'h0000_3000,0), 32'h1234_567F, 32'h0000_007F);
        run_load("alu",  mk(0,0,0,0,0,0,0,0,0,0,1,5'd9,32'h1234_5678,0), 32'hFFFF_FFFF, 32'h1234_5678);

        // mfc0 in MEM must raise the hazard flag
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5'd8, 32'h0000_BEEF, 0);
        step();
        es_to_ms_valid = 1'b0;
        at_neg();
        chk("mfc0_haz", 32'(ms_res_from_cp0_h), 32'd1);
        chk("mfc0_fwd", ms_forward, 32'h0000_BEEF);
        step();

        // an excepting instruction stalls in MEM, then WB flushes it while EXE offers a new one
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(1, 5'h04, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5'd5, 32'h0000_0001, 32'h0000_0080);
        step();
        es_to_ms_valid  = 1'b0;
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'h5555_AAAA;
        at_neg();
        chk("t4_exms",   32'(ex_from_ms), 32'd1);
        chk("t4_grwe",   32'(ms_to_ws_bus[101]), 32'd0);
        chk("t4_ex",     32'(ms_to_ws_bus[108]), 32'd1);
        chk("t4_excode", 32'(ms_to_ws_bus[107:103]), 32'h04);
        step();
        at_neg();
        chk("t4_exms_c2", 32'(ex_from_ms), 32'd1);
        chk("t4_held",    32'(dut.hold_state), 32'd1);
        step();
        ex_from_ws     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5'd6, 32'h0000_0200, 0);
        step();
        ex_from_ws     = 1'b0;
        es_to_ms_valid = 1'b0;
        at_neg();
        chk("t5_valid",   32'(ms_valid_h), 32'd0);
        chk("t5_wsvalid", 32'(ms_to_ws_valid), 32'd0);
        chk("t5_exms",    32'(ex_from_ms), 32'd0);
        chk("t5_held",    32'(dut.hold_state), 32'd0);
        step();
        ws_allowin = 1'b1;

        // reset arrives while read data is held
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5'd10, 32'h0000_0300, 0);
        step();
        es_to_ms_valid  = 1'b0;
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        step();
        data_sram_rdata = 32'h0;
        at_neg();
        chk("t6_held_fwd", ms_forward, 32'hCAFE_F00D);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        at_neg();
        chk("t6_valid", 32'(ms_valid_h), 32'd0);
        chk("t6_held",  32'(dut.hold_state), 32'd0);
        step();
        ws_allowin = 1'b1;
        run_load("t6_live", mk(0,0,0,0,0,0,1,0,0,0,1,5'd11,32'h0000_0304,0), 32'h1357_2468, 32'h1357_2468);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
